nib_mem_arbiter: RTL and testbench

NIB_MEM_ARBITER -- requirements
Module: nib_mem_arbiter

---
 rtl/nib_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_nib_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nib_mem_arbiter.sv
// Two-master arbiter (core data port and DMA) in front of a single-ported RAM.
// It allows one outstanding transaction and caps DMA bursts while the core is kept waiting.
module nib_mem_arbiter #(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
) (
  input  logic          clk,
  input  logic          rstn,
  // core data port
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  // DMA port
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  // shared RAM port
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  // status
  output logic          hold_req_o,
  output logic          bus_spare_o
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 32'd1);
  localparam logic [BCW-1:0] BURST_MAX  = BCW'(MAX_BURST);
  localparam logic [BCW-1:0] BURST_ONE  = BCW'(32'd1);
  localparam logic [BCW-1:0] BURST_ZERO = BCW'(32'd0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CORE = 2'd1,
    GNT_DMA  = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  state_t         state_r;
  state_t         state_s;
  owner_t         owner_r;
  owner_t         owner_s;
  logic [BCW-1:0] burst_r;
  logic [BCW-1:0] burst_s;

  logic           own_req_s;
  logic           own_we_s;
  logic [AW-1:0]  own_addr_s;
  logic [DW-1:0]  own_wdata_s;
  logic           in_gnt_s;
  logic           beat_s;
  logic           rd_ret_s;
  logic           dma_done_s;

  // Select the current owner's request; the other master is never looked at here.
  always_comb begin
    own_req_s   = core_req_i;
    own_we_s    = core_we_i;
    own_addr_s  = core_addr_i;
    own_wdata_s = core_wdata_i;
    if (owner_r == OWN_DMA) begin
      own_req_s   = dma_req_i;
      own_we_s    = dma_we_i;
      own_addr_s  = dma_addr_i;
      own_wdata_s = dma_wdata_i;
    end else begin
      own_req_s   = core_req_i;
      own_we_s    = core_we_i;
      own_addr_s  = core_addr_i;
      own_wdata_s = core_wdata_i;
    end
  end

  assign in_gnt_s = (state_r == GNT_CORE) || (state_r == GNT_DMA);

  // RAM request path: forwarded only while a grant state is active, zero otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {AW{1'b0}};
    mem_wdata_o = {DW{1'b0}};
    if (in_gnt_s) begin
      mem_req_o   = own_req_s;
      mem_we_o    = own_we_s;
      mem_addr_o  = own_addr_s;
      mem_wdata_o = own_wdata_s;
    end else begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = {AW{1'b0}};
      mem_wdata_o = {DW{1'b0}};
    end
  end

  assign beat_s        = mem_req_o & mem_gnt_i;
  assign core_gnt_o    = beat_s & (owner_r == OWN_CORE);
  assign dma_gnt_o     = beat_s & (owner_r == OWN_DMA);

  // A read return is only meaningful while waiting for it.
  assign rd_ret_s      = (state_r == RD_WAIT) & mem_rvalid_i;
  assign core_rvalid_o = rd_ret_s & (owner_r == OWN_CORE);
  assign dma_rvalid_o  = rd_ret_s & (owner_r == OWN_DMA);
  assign core_rdata_o  = mem_rdata_i;
  assign dma_rdata_o   = mem_rdata_i;

  assign hold_req_o    = (owner_r == OWN_DMA) && (state_r != IDLE);
  assign bus_spare_o   = (state_r == IDLE);

  // A DMA beat completes on an accepted write or on its read data returning.
  assign dma_done_s    = (dma_gnt_o & own_we_s) | dma_rvalid_o;

  // Arbitration and transaction sequencing.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    case (state_r)
      IDLE: begin
        if (dma_req_i && ((burst_r < BURST_MAX) || !core_req_i)) begin
          state_s = GNT_DMA;
          owner_s = OWN_DMA;
        end else if (core_req_i) begin
          state_s = GNT_CORE;
          owner_s = OWN_CORE;
        end else begin
          state_s = IDLE;
          owner_s = owner_r;
        end
      end
      GNT_CORE, GNT_DMA: begin
        if (!own_req_s) begin
          state_s = IDLE;
        end else if (beat_s) begin
          state_s = own_we_s ? IDLE : RD_WAIT;
        end else begin
          state_s = state_r;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          state_s = IDLE;
        end else begin
          state_s = RD_WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        owner_s = OWN_CORE;
      end
    endcase
  end

  // Burst length limiter: any core grant or a quiet DMA restarts the count.
  always_comb begin
    burst_s = burst_r;
    if (core_gnt_o || ((state_r == IDLE) && !dma_req_i)) begin
      burst_s = BURST_ZERO;
    end else if (dma_done_s && (burst_r < BURST_MAX)) begin
      burst_s = burst_r + BURST_ONE;
    end else begin
      burst_s = burst_r;
    end
  end

  // State, owner and burst registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      owner_r <= OWN_CORE;
      burst_r <= BURST_ZERO;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      burst_r <= burst_s;
    end
  end

endmodule

// File: tb/tb_nib_mem_arbiter.sv
// Bench for nib_mem_arbiter: a directed vector table, multi-cycle burst/reset sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_nib_mem_arbiter;

  localparam int MB = 4;
  localparam logic [31:0] CORE_WD = 32'hDEAD_BEEF;
  localparam logic [31:0] DMA_WD  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_req_i, core_we_i, dma_req_i, dma_we_i;
  logic [31:0] core_addr_i, core_wdata_i, dma_addr_i, dma_wdata_i;
  logic        core_gnt_o, core_rvalid_o, dma_gnt_o, dma_rvalid_o;
  logic [31:0] core_rdata_o, dma_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        hold_req_o, bus_spare_o;

  int n_vec = 0;
  int n_bad = 0;

  nib_mem_arbiter #(.MAX_BURST(MB), .AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o),
    .dma_rdata_o(dma_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .hold_req_o(hold_req_o), .bus_spare_o(bus_spare_o)
  );

  always #5 clk = ~clk;

  // flags = {mem_req, core_gnt, dma_gnt, core_rvalid, dma_rvalid, hold_req, bus_spare}
  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic        m_gnt, m_rv;
    logic [31:0] m_rdata;
    logic [6:0]  e_flags;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic cr, logic cw, logic [31:0] ca, logic dr, logic dw,
                              logic [31:0] da, logic mg, logic mv, logic [31:0] md,
                              logic [6:0] ef, logic ew, logic [31:0] ea, logic [31:0] ewd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca;
    v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.m_gnt = mg; v.m_rv = mv; v.m_rdata = md;
    v.e_flags = ef; v.e_we = ew; v.e_addr = ea; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] ef, input logic ewe,
                       input logic [31:0] eaddr, input logic [31:0] ewd, input logic [31:0] erd);
    logic [6:0] got;
    logic       ok;
    got = {mem_req_o, core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o, hold_req_o, bus_spare_o};
    ok = (got === ef);
    if (ef[6] && !(mem_we_o === ewe && mem_addr_o === eaddr && mem_wdata_o === ewd)) ok = 1'b0;
    if ((ef[3] || ef[2]) && !(core_rdata_o === erd && dma_rdata_o === erd)) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got flags=%b we=%b addr=%h wdata=%h rdata=%h/%h, expected flags=%b we=%b addr=%h wdata=%h rdata=%h",
               name, got, mem_we_o, mem_addr_o, mem_wdata_o, core_rdata_o, dma_rdata_o,
               ef, ewe, eaddr, ewd, erd);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_b [6];
    int          got_n;
    bit          act, who, rd;
    int          burst;
    int          d_prob;
    logic        ereq;
    logic [6:0]  ef;

    rstn = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = 32'h0; core_wdata_i = CORE_WD;
    dma_req_i = 1'b0;  dma_we_i = 1'b0;  dma_addr_i = 32'h0;  dma_wdata_i = DMA_WD;
    mem_gnt_i = 1'b0;  mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #2;
    check("reset_state", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // core write, core read with late return, simultaneous requests, DMA abandon
    tbl.push_back(mk(1,1,32'h100, 0,0,32'h0,   1,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(1,1,32'h100, 0,0,32'h0,   1,0,32'h0,      7'b1100000, 1, 32'h100, CORE_WD));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   1,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(1,0,32'h104, 0,0,32'h0,   1,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(1,0,32'h104, 0,0,32'h0,   1,0,32'h0,      7'b1100000, 0, 32'h104, CORE_WD));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   1,0,32'h0,      7'b0000000, 0, 32'h0,   32'h0));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   1,0,32'h0,      7'b0000000, 0, 32'h0,   32'h0));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   1,1,32'h12345678, 7'b0001000, 0, 32'h0, 32'h0));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   1,1,32'h0BAD0BAD, 7'b0000001, 0, 32'h0, 32'h0));
    tbl.push_back(mk(1,1,32'h200, 1,1,32'h300, 1,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(1,1,32'h200, 1,1,32'h300, 1,0,32'h0,      7'b1010010, 1, 32'h300, DMA_WD));
    tbl.push_back(mk(1,1,32'h200, 0,0,32'h0,   1,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(1,1,32'h200, 0,0,32'h0,   1,0,32'h0,      7'b1100000, 1, 32'h200, CORE_WD));
    tbl.push_back(mk(0,0,32'h0,   1,1,32'h300, 0,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));
    tbl.push_back(mk(0,0,32'h0,   1,1,32'h300, 0,0,32'h0,      7'b1000010, 1, 32'h300, DMA_WD));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,32'h0,      7'b0000010, 0, 32'h0,   32'h0));
    tbl.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,32'h0,      7'b0000001, 0, 32'h0,   32'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      core_req_i = tbl[i].c_req; core_we_i = tbl[i].c_we; core_addr_i = tbl[i].c_addr;
      dma_req_i = tbl[i].d_req;  dma_we_i = tbl[i].d_we;  dma_addr_i = tbl[i].d_addr;
      mem_gnt_i = tbl[i].m_gnt;  mem_rvalid_i = tbl[i].m_rv; mem_rdata_i = tbl[i].m_rdata;
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_flags, tbl[i].e_we, tbl[i].e_addr,
            tbl[i].e_wd, tbl[i].m_rdata);
    end

    // Burst cap: both masters stream writes; expect four DMA beats, one core beat, then DMA again.
    exp_b = '{1, 1, 1, 1, 0, 1};
    got_n = 0;
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h200;
    dma_req_i = 1'b1;  dma_we_i = 1'b1;  dma_addr_i = 32'h300;
    mem_gnt_i = 1'b1;  mem_rvalid_i = 1'b0;
    for (int cyc = 0; cyc < 40 && got_n < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (core_gnt_o || dma_gnt_o) begin
        n_vec++;
        if (dma_gnt_o !== (exp_b[got_n] == 1) || core_gnt_o === dma_gnt_o ||
            hold_req_o !== dma_gnt_o) begin
          n_bad++;
          $display("FAIL burst_beat%0d: dma_gnt=%b core_gnt=%b hold=%b, expected dma_gnt=%0d hold=%0d",
                   got_n, dma_gnt_o, core_gnt_o, hold_req_o, exp_b[got_n], exp_b[got_n]);
        end
        got_n++;
      end
    end
    if (got_n < 6) begin
      n_vec++;
      n_bad++;
      $display("FAIL burst_timeout: %0d beats seen, expected 6", got_n);
    end
    @(negedge clk);
    core_req_i = 1'b0; dma_req_i = 1'b0;

    // Asynchronous reset while a core read waits for mem_gnt_i.
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h104; mem_gnt_i = 1'b0;
    @(negedge clk);
    #1;
    check("gnt_core_wait", 7'b1000000, 1'b0, 32'h104, CORE_WD, 32'h0);
    rstn = 1'b0;
    #1;
    check("async_drop", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    core_req_i = 1'b0; rstn = 1'b1;
    #1;
    check("post_reset_idle", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);

    // Reset in RD_WAIT, then a stale read return after release.
    @(negedge clk);
    core_req_i = 1'b1; core_we_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    #1;
    check("rd_gnt", 7'b1100000, 1'b0, 32'h104, CORE_WD, 32'h0);
    @(negedge clk);
    core_req_i = 1'b0;
    #1;
    check("rd_wait", 7'b0000000, 1'b0, 32'h0, 32'h0, 32'h0);
    rstn = 1'b0;
    #1;
    check("reset_in_rd_wait", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    check("late_rvalid", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #1;
    check("idle_after_reset", 7'b0000001, 1'b0, 32'h0, 32'h0, 32'h0);

    // Randomized traffic against a transaction-level model: act = a transfer is in
    // progress, who = 1 for DMA, rd = waiting for read data, burst = DMA beats in a row.
    act = 1'b0; who = 1'b0; rd = 1'b0; burst = 0;
    for (int i = 0; i < 3000; i++) begin
      d_prob = ((i / 200) % 2 == 1) ? 97 : 50;
      @(negedge clk);
      core_req_i   = ($urandom_range(0, 99) < 60);
      core_we_i    = $urandom_range(0, 1);
      core_addr_i  = $urandom;
      core_wdata_i = $urandom;
      dma_req_i    = ($urandom_range(0, 99) < d_prob);
      dma_we_i     = $urandom_range(0, 1);
      dma_addr_i   = $urandom;
      dma_wdata_i  = $urandom;
      mem_gnt_i    = ($urandom_range(0, 99) < 55);
      mem_rvalid_i = ($urandom_range(0, 99) < 35);
      mem_rdata_i  = $urandom;
      #1;
      ereq = act && !rd && (who ? dma_req_i : core_req_i);
      ef = {ereq, ereq && mem_gnt_i && !who, ereq && mem_gnt_i && who,
            act && rd && mem_rvalid_i && !who, act && rd && mem_rvalid_i && who,
            act && who, !act};
      check("rand", ef, who ? dma_we_i : core_we_i, who ? dma_addr_i : core_addr_i,
            who ? dma_wdata_i : core_wdata_i, mem_rdata_i);
      if (!act) begin
        if (dma_req_i && (burst < MB || !core_req_i)) begin
          act = 1'b1; who = 1'b1;
        end else if (core_req_i) begin
          act = 1'b1; who = 1'b0;
        end
        if (!dma_req_i) burst = 0;
      end else if (!rd) begin
        if (!ereq) begin
          act = 1'b0;
        end else if (mem_gnt_i) begin
          if (!who) burst = 0;
          if (who ? dma_we_i : core_we_i) begin
            act = 1'b0;
            if (who && burst < MB) burst++;
          end else begin
            rd = 1'b1;
          end
        end
      end else if (mem_rvalid_i) begin
        act = 1'b0; rd = 1'b0;
        if (who && burst < MB) burst++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
